// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the two-requester UART TX scheduler.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam int   NUM_REQ        = 2;
    localparam logic LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Producer/transmitter side signals of the UART TX scheduler.
interface uart_tx_scheduler_if;

    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] UART_TXD;
    logic       TX_EN;
    logic       TX_STATUS;
    logic       grant_id;
    logic       tx_busy;
    logic       timeout_err;

    modport master (
        output req0_data,
        output req0_valid,
        input  req0_ready,
        output req1_data,
        output req1_valid,
        input  req1_ready,
        input  UART_TXD,
        input  TX_EN,
        output TX_STATUS,
        input  grant_id,
        input  tx_busy,
        input  timeout_err
    );

    modport slave (
        input  req0_data,
        input  req0_valid,
        output req0_ready,
        input  req1_data,
        input  req1_valid,
        output req1_ready,
        output UART_TXD,
        output TX_EN,
        input  TX_STATUS,
        output grant_id,
        output tx_busy,
        output timeout_err
    );

endinterface

// File: rtl/uart_tx_scheduler_byte_fifo.sv
// Register-based byte FIFO with registered full/empty flags.
module byte_fifo #(
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            do_push && !do_pop: count_nxt = count + 1'b1;
            do_pop && !do_push: count_nxt = count - 1'b1;
            default:            count_nxt = count;
        endcase
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between two FIFOs.
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    uart_tx_scheduler_if.slave bus
);

    import uart_tx_scheduler_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TIMEOUT - 1);

    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] empty;
    logic [NUM_REQ-1:0] avail;
    logic [7:0]         wdata [NUM_REQ];
    logic [7:0]         head  [NUM_REQ];
    logic [AW:0]        count [NUM_REQ];

    state_t        state;
    logic          last_grant;
    logic          sel;
    logic          do_pick;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    txd_q;
    logic          tx_en_q;
    logic          grant_q;
    logic          busy_q;
    logic          tmo_err_q;

    assign valid[0] = bus.req0_valid;
    assign valid[1] = bus.req1_valid;
    assign wdata[0] = bus.req0_data;
    assign wdata[1] = bus.req1_data;

    assign bus.req0_ready = !full[0];
    assign bus.req1_ready = !full[1];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        assign push[i]  = valid[i] && !full[i];
        assign avail[i] = (count[i] != '0);
        assign pop[i]   = do_pick && (sel == 1'(i)) && !empty[i];

        byte_fifo #(
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .sysclk   (sysclk),
            .reset    (reset),
            .push     (push[i]),
            .push_data(wdata[i]),
            .pop      (pop[i]),
            .pop_data (head[i]),
            .full     (full[i]),
            .empty    (empty[i]),
            .count    (count[i])
        );
    end

    // On a tie the requester not served last goes next.
    always_comb begin
        sel = 1'b0;
        unique case (1'b1)
            avail == 2'b11: sel = ~last_grant;
            avail == 2'b10: sel = 1'b1;
            default:        sel = 1'b0;
        endcase
    end

    assign do_pick = (state == IDLE) && bus.TX_STATUS && (|avail);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= LAST_GRANT_RST;
            tmo_cnt    <= '0;
            txd_q      <= '0;
            tx_en_q    <= 1'b0;
            grant_q    <= 1'b0;
            busy_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (do_pick) begin
                        txd_q      <= head[sel];
                        grant_q    <= sel;
                        last_grant <= sel;
                        tx_en_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= CW'(1);
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!bus.TX_STATUS) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Byte counts as sent; no retry.
                        tmo_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.TX_STATUS) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.UART_TXD    = txd_q;
    assign bus.TX_EN       = tx_en_q;
    assign bus.grant_id    = grant_q;
    assign bus.tx_busy     = busy_q;
    assign bus.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised and directed bench for uart_tx_scheduler against a queue model.
module tb_uart_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;

    uart_tx_scheduler_if bus ();

    uart_tx_scheduler #(
        .FIFO_DEPTH  (DEPTH),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 sysclk = ~sysclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-requester queues plus the round-robin rule.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] sent [$];
    int         sent_cyc [$];
    logic       last_g = 1'b1;
    logic       pend0 = 1'b0;
    logic       pend1 = 1'b0;
    logic [7:0] pd0, pd1;
    logic       prev_en = 1'b0;
    int         cyc = 0;
    int         busy_cnt = 0;

    int mode = 0;
    int busy_len = 10;
    bit rand_busy = 1'b0;
    int base = 0;

    always @(negedge sysclk) begin : mon
        logic       g;
        logic [7:0] b;
        cyc++;
        if (!reset) begin
            q0.delete();
            q1.delete();
            last_g  = 1'b1;
            pend0   = 1'b0;
            pend1   = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (bus.TX_EN === 1'b1) begin
                check("tx_en_gap", {31'd0, prev_en}, 0);
                if (q0.size() == 0 && q1.size() == 0) begin
                    check("tx_spurious", 1, 0);
                end else begin
                    if (q0.size() != 0 && q1.size() != 0) g = !last_g;
                    else g = (q0.size() == 0);
                    b = g ? q1.pop_front() : q0.pop_front();
                    last_g = g;
                    check("tx_grant", {31'd0, bus.grant_id}, {31'd0, g});
                    check("tx_byte", {24'd0, bus.UART_TXD}, {24'd0, b});
                end
                sent.push_back(bus.UART_TXD);
                sent_cyc.push_back(cyc);
            end
            prev_en = bus.TX_EN;
            if (pend0) q0.push_back(pd0);
            if (pend1) q1.push_back(pd1);
            check("rdy0", {31'd0, bus.req0_ready}, {31'd0, q0.size() < DEPTH});
            check("rdy1", {31'd0, bus.req1_ready}, {31'd0, q1.size() < DEPTH});
            pend0 = bus.req0_valid && (q0.size() < DEPTH);
            pend1 = bus.req1_valid && (q1.size() < DEPTH);
            pd0   = bus.req0_data;
            pd1   = bus.req1_data;
        end
        // Transmitter: 2 = held busy, 1 = never reacts, 0 = busy for a while.
        if (mode == 2) begin
            busy_cnt = 0;
            bus.TX_STATUS = 1'b0;
        end else if (mode == 1) begin
            busy_cnt = 0;
            bus.TX_STATUS = 1'b1;
        end else begin
            if (bus.TX_EN === 1'b1)
                busy_cnt = rand_busy ? int'($urandom_range(0, 5)) : busy_len;
            if (busy_cnt > 0) begin
                bus.TX_STATUS = 1'b0;
                busy_cnt--;
            end else begin
                bus.TX_STATUS = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    task automatic drive();
        @(posedge sysclk);
        #1;
    endtask

    function automatic int n_sent();
        return sent.size() - base;
    endfunction

    function automatic logic [31:0] sent_at(int i);
        if (base + i < sent.size()) return {24'd0, sent[base+i]};
        return 32'hxxxx_xxxx;
    endfunction

    task automatic wait_sent(int n, int bound, string tag);
        for (int i = 0; i < bound && n_sent() < n; i++) tick();
        check(tag, n_sent(), n);
    endtask

    task automatic wait_idle(int bound, string tag);
        for (int i = 0; i < bound && bus.tx_busy !== 1'b0; i++) tick();
        check(tag, {31'd0, bus.tx_busy}, 0);
    endtask

    task automatic check_rst(string p);
        check({p, "_txd"}, {24'd0, bus.UART_TXD}, 0);
        check({p, "_en"}, {31'd0, bus.TX_EN}, 0);
        check({p, "_gid"}, {31'd0, bus.grant_id}, 0);
        check({p, "_busy"}, {31'd0, bus.tx_busy}, 0);
        check({p, "_tmo"}, {31'd0, bus.timeout_err}, 0);
        check({p, "_rdy0"}, {31'd0, bus.req0_ready}, 1);
        check({p, "_rdy1"}, {31'd0, bus.req1_ready}, 1);
    endtask

    task automatic do_reset();
        drive();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        drive();
        reset = 1'b1;
        base = sent.size();
    endtask

    task automatic push0(logic [7:0] d);
        drive();
        bus.req0_valid = 1'b1;
        bus.req0_data  = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        logic [7:0] nxt;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_data  = 8'h00;
        repeat (3) tick();
        check_rst("rst");
        drive();
        reset = 1'b1;
        repeat (2) tick();

        // Single byte latency
        push0(8'h41);
        drive();
        bus.req0_valid = 1'b0;
        tick();
        check("t1_no_en", {31'd0, bus.TX_EN}, 0);
        tick();
        check("t1_en", {31'd0, bus.TX_EN}, 1);
        check("t1_txd", {24'd0, bus.UART_TXD}, 32'h41);
        check("t1_gid", {31'd0, bus.grant_id}, 0);
        check("t1_busy", {31'd0, bus.tx_busy}, 1);
        wait_idle(60, "t1_idle");
        check("t1_status", {31'd0, bus.TX_STATUS}, 1);

        // Round-robin
        mode = 2;
        do_reset();
        drive();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h10;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h20;
        drive();
        bus.req0_data = 8'h11;
        bus.req1_data = 8'h21;
        drive();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        busy_len = 3;
        mode = 0;
        wait_sent(4, 300, "t2_count");
        check("t2_b0", sent_at(0), 32'h10);
        check("t2_b1", sent_at(1), 32'h20);
        check("t2_b2", sent_at(2), 32'h11);
        check("t2_b3", sent_at(3), 32'h21);

        // Full FIFO
        mode = 2;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive();
            bus.req1_valid = 1'b1;
            bus.req1_data  = 8'h50 + 8'(k);
            if (k == 4) begin
                tick();
                check("t3_full", {31'd0, bus.req1_ready}, 0);
            end
        end
        drive();
        bus.req1_valid = 1'b0;
        mode = 0;
        wait_sent(4, 300, "t3_count");
        for (int k = 0; k < 4; k++)
            check("t3_order", sent_at(k), 32'h50 + k);
        repeat (30) tick();
        check("t3_no_5th", n_sent(), 4);

        // Timeout
        mode = 2;
        do_reset();
        push0(8'hA1);
        push0(8'hB2);
        drive();
        bus.req0_valid = 1'b0;
        mode = 1;
        wait_sent(1, 100, "t4_first");
        e = sent_cyc[base];
        for (int i = 0; i < 40 && bus.timeout_err !== 1'b1; i++) tick();
        check("t4_tmo_set", {31'd0, bus.timeout_err}, 1);
        check("t4_tmo_cyc", cyc - e, TMO);
        wait_sent(2, 100, "t4_second");
        check("t4_b1", sent_at(1), 32'hB2);
        check("t4_b1_cyc", sent_cyc[base+1] - e, TMO + 1);
        wait_idle(60, "t4_idle");
        check("t4_sticky", {31'd0, bus.timeout_err}, 1);

        // Reset while WAIT_DONE with two bytes queued
        mode = 2;
        do_reset();
        busy_len = 30;
        push0(8'hC0);
        push0(8'hC1);
        push0(8'hC2);
        drive();
        bus.req0_valid = 1'b0;
        mode = 0;
        wait_sent(1, 100, "t5_first");
        repeat (4) tick();
        check("t5_wd_busy", {31'd0, bus.tx_busy}, 1);
        check("t5_wd_status", {31'd0, bus.TX_STATUS}, 0);
        drive();
        reset = 1'b0;
        tick();
        check_rst("t5_rst");
        drive();
        reset = 1'b1;
        repeat (40) tick();
        check("t5_no_tx", n_sent(), 1);
        push0(8'h77);
        drive();
        bus.req0_valid = 1'b0;
        wait_sent(2, 100, "t5_new");
        check("t5_b1", sent_at(1), 32'h77);

        // Streaming refill of a full FIFO
        mode = 2;
        do_reset();
        for (int k = 0; k < 4; k++) push0(8'h30 + 8'(k));
        drive();
        bus.req0_valid = 1'b0;
        tick();
        check("t6_full", {31'd0, bus.req0_ready}, 0);
        busy_len = 2;
        mode = 0;
        nxt = 8'h34;
        drive();
        bus.req0_valid = 1'b1;
        bus.req0_data  = nxt;
        for (int i = 0; i < 400 && nxt != 8'h3C; i++) begin
            tick();
            if (bus.req0_ready === 1'b1) nxt++;
            drive();
            bus.req0_data = nxt;
            if (nxt == 8'h3C) bus.req0_valid = 1'b0;
        end
        check("t6_stream", {24'd0, nxt}, 32'h3C);
        wait_sent(12, 600, "t6_count");
        for (int k = 0; k < 12; k++)
            check("t6_order", sent_at(k), 32'h30 + k);

        // Random traffic with random transmitter delays
        rand_busy = 1'b1;
        mode = 0;
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            drive();
            bus.req0_valid = ($urandom_range(0, 1) == 0);
            bus.req1_valid = ($urandom_range(0, 2) == 0);
            bus.req0_data  = 8'($urandom);
            bus.req1_data  = 8'($urandom);
        end
        drive();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 2000 && (q0.size() + q1.size() != 0 ||
                                     bus.tx_busy !== 1'b0); i++)
            tick();
        check("rnd_drained", q0.size() + q1.size(), 0);
        check("rnd_idle", {31'd0, bus.tx_busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
